// File: rtl/dm_io_port_8085.sv
// Memory-mapped TX/RX byte FIFO port on the 8085 data-memory bus.
// Define DM_IO_IRQ_EN to add the IE register (+3 stores) and the irq output.
module dm_io_port_8085 #(
    parameter logic [7:0] BASE  = 8'hF0,
    parameter int          DEPTH = 4,
    parameter int          AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef DM_IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]  tx_mem_q [DEPTH];
    logic [7:0]  tx_mem_d [DEPTH];
    logic [AW-1:0] tx_rp_q, tx_rp_d, tx_wp_q, tx_wp_d;
    logic [AW:0] tx_cnt_q, tx_cnt_d;
    logic        tx_ovf_q, tx_ovf_d;

    logic [7:0]  rx_mem_q [DEPTH];
    logic [7:0]  rx_mem_d [DEPTH];
    logic [AW-1:0] rx_rp_q, rx_rp_d, rx_wp_q, rx_wp_d;
    logic [AW:0] rx_cnt_q, rx_cnt_d;

    logic [7:0] off;
    logic       wr_en, rd_en;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] rd_byte;
    logic       unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[15:8];

    // Offset arithmetic wraps mod 256, so a BASE near 8'hFF still decodes 4 slots.
    assign off   = addr - BASE;
    assign hit   = (off[7:2] == 6'd0);
    assign wr_en = wr & hit;
    assign rd_en = rd & ~wr & hit;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    assign tx_push_req = wr_en & (off[1:0] == 2'd0);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = ~tx_empty & tx_ready;
    assign rx_push     = rx_valid & ~rx_full;
    assign rx_pop      = rd_en & (off[1:0] == 2'd1) & ~rx_empty;

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
    assign rx_ready = ~rx_full;

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_rp_d  = tx_rp_q;
        tx_wp_d  = tx_wp_q;
        tx_cnt_d = tx_cnt_q;
        tx_ovf_d = tx_ovf_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = wdata[7:0];
            tx_wp_d = tx_wp_q + 1'b1;
        end
        if (tx_pop) tx_rp_d = tx_rp_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        if (tx_push_req & tx_full)
            tx_ovf_d = 1'b1;
        else if (wr_en & (off[1:0] == 2'd2) & wdata[4])
            tx_ovf_d = 1'b0;
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_rp_d  = rx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_data;
            rx_wp_d = rx_wp_q + 1'b1;
        end
        if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        if (rd & hit) begin
            unique case (off[1:0])
                2'd0: rd_byte = 8'h00;
                2'd1: rd_byte = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
                2'd2: rd_byte = {3'b000, tx_ovf_q, rx_full, rx_empty,
                                 tx_full, tx_empty};
                2'd3: rd_byte = {4'(rx_cnt_q), 4'(tx_cnt_q)};
            endcase
        end
    end

    assign rdata = {8'h00, rd_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_mem_q <= '{default: '0};
            tx_rp_q  <= '0;
            tx_wp_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_mem_q <= '{default: '0};
            rx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_mem_q <= tx_mem_d;
            tx_rp_q  <= tx_rp_d;
            tx_wp_q  <= tx_wp_d;
            tx_cnt_q <= tx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_mem_q <= rx_mem_d;
            rx_rp_q  <= rx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

`ifdef DM_IO_IRQ_EN
    logic [1:0] ie_q, ie_d;
    logic       irq_q, irq_d;

    always_comb begin
        ie_d  = ie_q;
        if (wr_en & (off[1:0] == 2'd3)) ie_d = wdata[1:0];
        irq_d = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
